bldc_commutator_dt: RTL and testbench

// - Six-step BLDC commutator, successor to the basic commutator.
// - Adds per-phase dead-time insertion, 2-flop Hall synchroniser, Hall fault/stall detection and live direction change.
// - Sits between the 3-phase PWM generator and the gate-driver pins.
// - Closed-loop mode follows the Hall sensors; open-loop mode steps on a programmable timer.

---
 rtl/bldc_pkg.sv | 68 ++++++
 rtl/bldc_deadtime_phase.sv | 57 +++++
 rtl/bldc_commutator_dt.sv | 148 ++++++++++++++
 tb/tb_bldc_commutator_dt.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared types and lookup tables for the six-step commutator: phase requests,
// step/Hall decoding and fault codes.
package bldc_pkg;

  typedef enum logic [1:0] {
    PH_OFF = 2'd0,
    PH_HI  = 2'd1,
    PH_LO  = 2'd2
  } phase_req_e;

  typedef struct packed {
    phase_req_e a;
    phase_req_e b;
    phase_req_e c;
  } step_req_t;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_HALL  = 2'd1;
  localparam logic [1:0] FAULT_STALL = 2'd2;

  function automatic step_req_t step_to_req(input logic [2:0] step);
    step_req_t r;
    r.a = PH_OFF;
    r.b = PH_OFF;
    r.c = PH_OFF;
    case (step)
      3'd0: begin r.a = PH_HI; r.b = PH_LO; end
      3'd1: begin r.a = PH_HI; r.c = PH_LO; end
      3'd2: begin r.b = PH_HI; r.c = PH_LO; end
      3'd3: begin r.b = PH_HI; r.a = PH_LO; end
      3'd4: begin r.c = PH_HI; r.a = PH_LO; end
      3'd5: begin r.c = PH_HI; r.b = PH_LO; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic hall_valid(input logic [2:0] hall);
    return (hall != 3'b000) && (hall != 3'b111);
  endfunction

  function automatic logic [2:0] hall_to_step(input logic [2:0] hall);
    logic [2:0] s;
    case (hall)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] step_fwd(input logic [2:0] s);
    return (s >= 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] step_rev(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  function automatic logic [2:0] step_add3(input logic [2:0] s);
    return (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
  endfunction

endpackage

// File: rtl/bldc_deadtime_phase.sv
// One inverter leg: turns a HI/LO/OFF request into registered high/low gate
// drives, blanking both switches for DEADTIME_CYCLES after each new request.
module bldc_deadtime_phase
  import bldc_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  phase_req_e i_req,
  input  logic       i_pwm,
  input  logic       i_fault,
  output logic       o_gate_h,
  output logic       o_gate_l
);

  localparam int CNT_W = (DEADTIME_CYCLES > 0) ? $clog2(DEADTIME_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEADTIME_CYCLES);

  phase_req_e       r_req_prev;
  logic [CNT_W-1:0] r_blank_cnt;
  logic             r_gate_h;
  logic             r_gate_l;
  logic             w_change;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_blank;

  // OFF needs no blanking; any switch being turned on waits out the full count
  always_comb begin
    w_change   = (i_req != r_req_prev);
    w_cnt_next = '0;
    if (w_change) begin
      w_cnt_next = (i_req == PH_OFF) ? '0 : DT_LOAD;
    end else if (r_blank_cnt != '0) begin
      w_cnt_next = r_blank_cnt - CNT_W'(1);
    end
    w_blank = (w_cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_prev  <= PH_OFF;
      r_blank_cnt <= '0;
      r_gate_h    <= 1'b0;
      r_gate_l    <= 1'b0;
    end else begin
      r_req_prev  <= i_req;
      r_blank_cnt <= w_cnt_next;
      r_gate_h    <= i_pwm & (i_req == PH_HI) & ~w_blank & ~i_fault;
      r_gate_l    <= (i_req == PH_LO) & ~w_blank & ~i_fault;
    end
  end

  assign o_gate_h = r_gate_h;
  assign o_gate_l = r_gate_l;

endmodule

// File: rtl/bldc_commutator_dt.sv
// Six-step BLDC commutator with Hall synchroniser, open-loop step timer,
// Hall/stall fault detection and per-phase dead-time gate drivers.
module bldc_commutator_dt
  import bldc_pkg::*;
#(
  parameter int                     DEADTIME_CYCLES = 4,
  parameter int                     STEP_CNT_W      = 32,
  parameter int                     STALL_CNT_W     = 24,
  parameter logic [STALL_CNT_W-1:0] STALL_CYCLES    = 24'd1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  use_hall,
  input  logic                  direction,
  input  logic [2:0]            hall_sensors,
  input  logic                  pwm_A,
  input  logic                  pwm_B,
  input  logic                  pwm_C,
  input  logic [STEP_CNT_W-1:0] open_loop_step_duration,
  output logic                  gate_H_A,
  output logic                  gate_H_B,
  output logic                  gate_H_C,
  output logic                  gate_L_A,
  output logic                  gate_L_B,
  output logic                  gate_L_C,
  output logic [2:0]            step,
  output logic                  comm_strobe,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  logic [2:0]             r_hall_p0;
  logic [2:0]             r_hall_p1;
  logic [2:0]             r_hall_p2;
  logic [2:0]             r_step;
  logic [STEP_CNT_W-1:0]  r_timer;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_fault;
  logic [1:0]             r_fault_code;
  logic                   r_strobe;

  logic                   w_hall_ok;
  logic                   w_hall_edge;
  logic [2:0]             w_hall_step;
  logic [STEP_CNT_W-1:0]  w_dur_m1;
  logic                   w_stall_hit;
  step_req_t              w_req;

  // Hall synchroniser: p0/p1 are the two sync flops, p2 holds the previous synced value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hall_p0 <= '0;
      r_hall_p1 <= '0;
      r_hall_p2 <= '0;
    end else begin
      r_hall_p0 <= hall_sensors;
      r_hall_p1 <= r_hall_p0;
      r_hall_p2 <= r_hall_p1;
    end
  end

  always_comb begin
    w_hall_ok   = hall_valid(r_hall_p1);
    w_hall_edge = (r_hall_p1 != r_hall_p2);
    w_hall_step = direction ? step_add3(hall_to_step(r_hall_p1)) : hall_to_step(r_hall_p1);
    w_dur_m1    = (open_loop_step_duration == '0) ? '0
                : open_loop_step_duration - STEP_CNT_W'(1);
    w_stall_hit = (r_stall_cnt == STALL_CYCLES - STALL_CNT_W'(1)) && !w_hall_edge;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_step       <= '0;
      r_timer      <= '0;
      r_stall_cnt  <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= FAULT_NONE;
      r_strobe     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (!use_hall || w_hall_edge) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != STALL_CYCLES) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
      // first fault wins; its code is held until enable drops
      if (!r_fault && use_hall) begin
        if (!w_hall_ok) begin
          r_fault      <= 1'b1;
          r_fault_code <= FAULT_HALL;
        end else if (w_stall_hit) begin
          r_fault      <= 1'b1;
          r_fault_code <= FAULT_STALL;
        end
      end
      if (r_fault || use_hall) begin
        r_timer <= '0;
      end else if (r_timer >= w_dur_m1) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + STEP_CNT_W'(1);
      end
      if (!r_fault) begin
        if (use_hall) begin
          if (w_hall_ok && (w_hall_step != r_step)) begin
            r_step   <= w_hall_step;
            r_strobe <= 1'b1;
          end
        end else if (r_timer >= w_dur_m1) begin
          r_step   <= direction ? step_rev(r_step) : step_fwd(r_step);
          r_strobe <= 1'b1;
        end
      end
    end
  end

  // Disabled legs request OFF so re-enabling always starts with full blanking
  always_comb begin
    w_req.a = PH_OFF;
    w_req.b = PH_OFF;
    w_req.c = PH_OFF;
    if (enable) begin
      w_req = step_to_req(r_step);
    end
  end

  bldc_deadtime_phase #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_phase_a (
    .clk(clk), .reset(reset), .i_req(w_req.a), .i_pwm(pwm_A), .i_fault(r_fault),
    .o_gate_h(gate_H_A), .o_gate_l(gate_L_A)
  );

  bldc_deadtime_phase #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_phase_b (
    .clk(clk), .reset(reset), .i_req(w_req.b), .i_pwm(pwm_B), .i_fault(r_fault),
    .o_gate_h(gate_H_B), .o_gate_l(gate_L_B)
  );

  bldc_deadtime_phase #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_phase_c (
    .clk(clk), .reset(reset), .i_req(w_req.c), .i_pwm(pwm_C), .i_fault(r_fault),
    .o_gate_h(gate_H_C), .o_gate_l(gate_L_C)
  );

  assign step        = r_step;
  assign comm_strobe = r_strobe;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;

endmodule

// File: tb/tb_bldc_commutator_dt.sv
// Directed bench for bldc_commutator_dt: open/closed loop stepping, dead-time,
// direction changes, faults, reset mid-blanking and a random shoot-through watch.
module tb_bldc_commutator_dt;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        use_hall;
  logic        direction;
  logic [2:0]  hall_sensors;
  logic        pwm_A, pwm_B, pwm_C;
  logic [31:0] open_loop_step_duration;
  logic        gate_H_A, gate_H_B, gate_H_C;
  logic        gate_L_A, gate_L_B, gate_L_C;
  logic [2:0]  step;
  logic        comm_strobe;
  logic        fault;
  logic [1:0]  fault_code;

  logic [5:0]  gates;
  logic [12:0] all_out;
  int          n_tests;
  int          n_fail;
  int          overlap_cnt;

  assign gates   = {gate_H_A, gate_H_B, gate_H_C, gate_L_A, gate_L_B, gate_L_C};
  assign all_out = {gates, step, comm_strobe, fault, fault_code};

  bldc_commutator_dt #(
    .DEADTIME_CYCLES(4),
    .STEP_CNT_W(32),
    .STALL_CNT_W(24),
    .STALL_CYCLES(24'd50)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .use_hall(use_hall),
    .direction(direction), .hall_sensors(hall_sensors),
    .pwm_A(pwm_A), .pwm_B(pwm_B), .pwm_C(pwm_C),
    .open_loop_step_duration(open_loop_step_duration),
    .gate_H_A(gate_H_A), .gate_H_B(gate_H_B), .gate_H_C(gate_H_C),
    .gate_L_A(gate_L_A), .gate_L_B(gate_L_B), .gate_L_C(gate_L_C),
    .step(step), .comm_strobe(comm_strobe), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial overlap_cnt = 0;
  always @(negedge clk) begin
    if ((gate_H_A & gate_L_A) | (gate_H_B & gate_L_B) | (gate_H_C & gate_L_C))
      overlap_cnt = overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] hall_seq [5];
    int n_strobe;
    int trk_err;
    n_tests = 0;
    n_fail  = 0;
    hall_seq[0] = 3'b100; hall_seq[1] = 3'b110; hall_seq[2] = 3'b010;
    hall_seq[3] = 3'b011; hall_seq[4] = 3'b001;

    reset = 1'b1; enable = 1'b0; use_hall = 1'b0; direction = 1'b0;
    hall_sensors = 3'b101; pwm_A = 1'b1; pwm_B = 1'b1; pwm_C = 1'b1;
    open_loop_step_duration = 32'd100;
    repeat (3) tick();
    chk("reset_outputs", 32'(all_out), 32'd0);
    reset = 1'b0;
    tick();

    // open loop forward, dur=100
    n_strobe = 0;
    trk_err  = 0;
    enable = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (comm_strobe) n_strobe++;
      if (step !== 3'((i / 100) % 6)) trk_err++;
      if (i == 4)   chk("dt_start_blank", 32'(gates), 32'd0);
      if (i == 5)   chk("dt_start_on", 32'(gates), 32'b100010);
      if (i == 50)  pwm_A = 1'b0;
      if (i == 51) begin
        chk("pwm_gates_high", 32'(gates), 32'b000010);
        pwm_A = 1'b1;
      end
      if (i == 99)  chk("ol_step_hold", 32'(step), 32'd0);
      if (i == 100) begin
        chk("ol_step_adv", 32'(step), 32'd1);
        chk("ol_strobe", 32'(comm_strobe), 32'd1);
        chk("dt_before_drop", 32'(gates), 32'b100010);
      end
      if (i == 101) begin
        chk("dt_drop_LB", 32'(gates), 32'b100000);
        chk("ol_strobe_1cyc", 32'(comm_strobe), 32'd0);
      end
      if (i == 104) chk("dt_LC_blank", 32'(gates), 32'b100000);
      if (i == 105) chk("dt_LC_on", 32'(gates), 32'b100001);
    end
    chk("ol_fwd_track", 32'(trk_err), 32'd0);
    chk("ol_strobe_count", 32'(n_strobe), 32'd6);
    chk("ol_wrap_step", 32'(step), 32'd0);

    // reverse, then a mid-run direction toggle
    direction = 1'b1;
    repeat (100) tick();
    chk("rev_step_0to5", 32'(step), 32'd5);
    repeat (100) tick();
    chk("rev_step_5to4", 32'(step), 32'd4);
    repeat (50) tick();
    direction = 1'b0;
    repeat (50) tick();
    chk("dir_toggle_fwd", 32'(step), 32'd5);

    enable = 1'b0;
    tick();
    chk("disable_gates", 32'(gates), 32'd0);
    chk("disable_step", 32'(step), 32'd0);

    // closed loop forward
    use_hall = 1'b1;
    direction = 1'b0;
    enable = 1'b1;
    tick();
    chk("hall_start_step", 32'(step), 32'd0);
    chk("hall_start_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 5; k++) begin
      hall_sensors = hall_seq[k];
      repeat (2) tick();
      chk("hall_step_lat2", 32'(step), 32'(k));
      tick();
      chk("hall_step_lat3", 32'(step), 32'(k + 1));
      chk("hall_strobe", 32'(comm_strobe), 32'd1);
      repeat (5) tick();
    end

    // closed loop reverse
    direction = 1'b1;
    tick();
    chk("hall_rev_live", 32'(step), 32'd2);
    chk("hall_rev_strobe", 32'(comm_strobe), 32'd1);
    hall_sensors = 3'b101;
    repeat (3) tick();
    chk("hall_rev_101", 32'(step), 32'd3);

    // invalid Hall fault
    hall_sensors = 3'b111;
    repeat (2) tick();
    chk("inv_fault_early", 32'(fault), 32'd0);
    tick();
    chk("inv_fault_set", 32'({fault, fault_code}), 32'b101);
    tick();
    chk("inv_gates_off", 32'(gates), 32'd0);
    chk("inv_step_frozen", 32'(step), 32'd3);
    hall_sensors = 3'b101;
    repeat (60) tick();
    chk("fault_sticky_code", 32'({fault, fault_code}), 32'b101);
    chk("fault_step_frozen", 32'(step), 32'd3);
    enable = 1'b0;
    tick();
    chk("fault_clear", 32'({fault, fault_code, step}), 32'd0);

    // stall fault with STALL_CYCLES=50
    direction = 1'b0;
    enable = 1'b1;
    repeat (49) tick();
    chk("stall_early", 32'(fault), 32'd0);
    tick();
    chk("stall_fault", 32'({fault, fault_code}), 32'b110);
    tick();
    chk("stall_gates_off", 32'(gates), 32'd0);
    enable = 1'b0;
    tick();
    chk("stall_clear", 32'({fault, fault_code}), 32'd0);

    // zero duration behaves as one cycle per step
    use_hall = 1'b0;
    open_loop_step_duration = 32'd0;
    enable = 1'b1;
    tick();
    chk("dur0_step1", 32'(step), 32'd1);
    tick();
    chk("dur0_step2", 32'({step, comm_strobe}), 32'b0101);
    enable = 1'b0;
    tick();

    // reset in the middle of blanking
    open_loop_step_duration = 32'd100;
    enable = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_blank", 32'(all_out), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("post_reset_blank", 32'(gates), 32'd0);
    tick();
    chk("post_reset_on", 32'(gates), 32'b100010);

    // random activity, watched for shoot-through
    for (int i = 0; i < 20000; i++) begin
      pwm_A = 1'($urandom);
      pwm_B = 1'($urandom);
      pwm_C = 1'($urandom);
      if ($urandom_range(0, 7) == 0)   hall_sensors = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0)  direction = ~direction;
      if ($urandom_range(0, 255) == 0) use_hall = ~use_hall;
      if ($urandom_range(0, 127) == 0) enable = ~enable;
      reset = ($urandom_range(0, 511) == 0);
      open_loop_step_duration = 32'($urandom_range(0, 12));
      tick();
    end
    reset = 1'b1;
    tick();
    chk("random_reset_outputs", 32'(all_out), 32'd0);
    reset = 1'b0;
    tick();
    chk("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
